// File: rtl/ddr_iod_delay_stepper.sv
// ddr_iod_delay_stepper: per-lane IOD delay-line tap controller.
// Accepts one tap-move request at a time, issues LOAD/MOVE/DIRECTION pulses on
// the selected channel with settle gaps, and keeps a shadow tap per channel.
module ddr_iod_delay_stepper #(
  parameter  int unsigned NUM_CH   = 9,
  parameter  int unsigned TAP_W    = 8,
  parameter  int unsigned MAX_TAP  = 255,
  parameter  int unsigned INIT_TAP = 1,
  parameter  int unsigned MOVE_GAP = 3,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    FAB_CLK,
  input  logic                    SYNC_RST,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic [CH_W-1:0]         REQ_CH,
  input  logic [TAP_W-1:0]        REQ_TAP,
  input  logic                    REQ_LOAD,
  output logic                    DONE,
  output logic                    DONE_ERR,
  output logic [NUM_CH-1:0]       DELAY_LINE_LOAD,
  output logic [NUM_CH-1:0]       DELAY_LINE_MOVE,
  output logic [NUM_CH-1:0]       DELAY_LINE_DIRECTION,
  input  logic [NUM_CH-1:0]       DELAY_LINE_OUT_OF_RANGE,
  output logic [NUM_CH*TAP_W-1:0] TAP_OUT
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETUP, S_MOVE, S_GAP, S_DONE
  } state_e;

  localparam logic [TAP_W-1:0] INIT_T   = TAP_W'(INIT_TAP);
  localparam logic [TAP_W-1:0] ONE_T    = TAP_W'(1);
  localparam logic [3:0]       GAP_LAST = 4'(MOVE_GAP - 1);

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [TAP_W-1:0]   tgt_q, tgt_d;
  logic [3:0]         gap_q, gap_d;
  logic               post_move_q, post_move_d;
  logic               err_q, err_d;
  logic               dir_q, dir_d;
  logic [TAP_W-1:0]   tap_q [NUM_CH];
  logic [TAP_W-1:0]   tap_d [NUM_CH];
  logic [TAP_W-1:0]   cur_tap, req_cur_tap;
  logic [NUM_CH-1:0]  sel_q, sel_d, req_sel;
  logic               req_bad, oor_sel;
  logic [NUM_CH-1:0]  load_q, load_d, move_q, move_d, dirv_q, dirv_d;
  logic               done_q, done_d, done_err_q, done_err_d, rdy_q, rdy_d;

  function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] ch);
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) v[c] = (ch == CH_W'(c));
    return v;
  endfunction

  // Channel decode and shadow-tap lookup for the latched and the incoming channel.
  always_comb begin
    sel_q       = onehot(ch_q);
    req_sel     = onehot(REQ_CH);
    cur_tap     = '0;
    req_cur_tap = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (sel_q[c])   cur_tap     = tap_q[c];
      if (req_sel[c]) req_cur_tap = tap_q[c];
    end
    oor_sel = |(DELAY_LINE_OUT_OF_RANGE & sel_q);
    req_bad = (32'(REQ_CH) >= NUM_CH) || (32'(REQ_TAP) > MAX_TAP);
  end

  // State, request, shadow-tap and registered-output flops.
  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      tgt_q       <= '0;
      gap_q       <= '0;
      post_move_q <= 1'b0;
      err_q       <= 1'b0;
      dir_q       <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) tap_q[c] <= INIT_T;
      load_q      <= '0;
      move_q      <= '0;
      dirv_q      <= '0;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      tgt_q       <= tgt_d;
      gap_q       <= gap_d;
      post_move_q <= post_move_d;
      err_q       <= err_d;
      dir_q       <= dir_d;
      for (int unsigned c = 0; c < NUM_CH; c++) tap_q[c] <= tap_d[c];
      load_q      <= load_d;
      move_q      <= move_d;
      dirv_q      <= dirv_d;
      done_q      <= done_d;
      done_err_q  <= done_err_d;
      rdy_q       <= rdy_d;
    end
  end

  // Next-state and datapath update. Direction is fixed on entry to SETUP so it
  // is already valid in the first SETUP cycle and held until DONE.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    tgt_d       = tgt_q;
    gap_d       = gap_q;
    post_move_d = post_move_q;
    err_d       = err_q;
    dir_d       = dir_q;
    tap_d       = tap_q;
    case (state_q)
      S_IDLE: begin
        if (REQ_VALID && rdy_q) begin
          ch_d  = REQ_CH;
          tgt_d = REQ_TAP;
          err_d = 1'b0;
          if (req_bad) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (REQ_LOAD) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_SETUP;
            dir_d   = (REQ_TAP > req_cur_tap);
          end
        end
      end
      S_LOAD: begin
        for (int unsigned c = 0; c < NUM_CH; c++) if (sel_q[c]) tap_d[c] = INIT_T;
        gap_d       = GAP_LAST;
        post_move_d = 1'b0;
        state_d     = S_GAP;
      end
      S_SETUP: state_d = (cur_tap == tgt_q) ? S_DONE : S_MOVE;
      S_MOVE: begin
        for (int unsigned c = 0; c < NUM_CH; c++)
          if (sel_q[c]) tap_d[c] = dir_q ? cur_tap + ONE_T : cur_tap - ONE_T;
        gap_d       = GAP_LAST;
        post_move_d = 1'b1;
        state_d     = S_GAP;
      end
      S_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 4'd1;
        end else if (!post_move_q) begin
          state_d = S_SETUP;
          dir_d   = (tgt_q > cur_tap);
        end else if (oor_sel) begin
          for (int unsigned c = 0; c < NUM_CH; c++)
            if (sel_q[c]) tap_d[c] = dir_q ? cur_tap - ONE_T : cur_tap + ONE_T;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = (cur_tap == tgt_q) ? S_DONE : S_MOVE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE || state_d == S_LOAD || state_d == S_DONE) dir_d = 1'b0;
  end

  // Output decode from the next state; registered in the flop block above.
  always_comb begin
    sel_d      = onehot(ch_d);
    load_d     = (state_d == S_LOAD) ? sel_d : '0;
    move_d     = (state_d == S_MOVE) ? sel_d : '0;
    dirv_d     = dir_d ? sel_d : '0;
    done_d     = (state_d == S_DONE);
    done_err_d = (state_d == S_DONE) && err_d;
    rdy_d      = (state_d == S_IDLE);
  end

  assign REQ_READY            = rdy_q;
  assign DONE                 = done_q;
  assign DONE_ERR             = done_err_q;
  assign DELAY_LINE_LOAD      = load_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_DIRECTION = dirv_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_tap_out
    assign TAP_OUT[g*TAP_W +: TAP_W] = tap_q[g];
  end

endmodule

// File: tb/tb_ddr_iod_delay_stepper.sv
// Directed testbench for ddr_iod_delay_stepper (default parameters, plus a
// TAP_W=9 instance for the out-of-range target reject).
module tb_ddr_iod_delay_stepper;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_load, done, done_err;
  logic [3:0]  req_ch;
  logic [7:0]  req_tap;
  logic [8:0]  dl_load, dl_move, dl_dir, dl_oor;
  logic [71:0] tap_out;

  logic        r9_valid, r9_ready, r9_load, r9_done, r9_err;
  logic [3:0]  r9_ch;
  logic [8:0]  r9_tap;
  logic [8:0]  r9_dl_load, r9_dl_move, r9_dl_dir, r9_oor;
  logic [80:0] r9_tap_out;

  int tests  = 0;
  int failed = 0;
  int shadow [9];

  logic [8:0]  cap_ld [0:31];
  logic [8:0]  cap_mv [0:31];
  logic [8:0]  cap_dr [0:31];
  logic        cap_dn [0:31];
  logic        cap_de [0:31];
  logic        cap_rdy [0:31];
  logic [71:0] cap_tap [0:31];

  always #5 clk = ~clk;

  ddr_iod_delay_stepper u_dut (
    .FAB_CLK(clk), .SYNC_RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_CH(req_ch), .REQ_TAP(req_tap), .REQ_LOAD(req_load), .DONE(done),
    .DONE_ERR(done_err), .DELAY_LINE_LOAD(dl_load), .DELAY_LINE_MOVE(dl_move),
    .DELAY_LINE_DIRECTION(dl_dir), .DELAY_LINE_OUT_OF_RANGE(dl_oor), .TAP_OUT(tap_out)
  );

  ddr_iod_delay_stepper #(.NUM_CH(9), .TAP_W(9), .MAX_TAP(255), .INIT_TAP(1), .MOVE_GAP(3)) u_dut9 (
    .FAB_CLK(clk), .SYNC_RST(rst), .REQ_VALID(r9_valid), .REQ_READY(r9_ready),
    .REQ_CH(r9_ch), .REQ_TAP(r9_tap), .REQ_LOAD(r9_load), .DONE(r9_done),
    .DONE_ERR(r9_err), .DELAY_LINE_LOAD(r9_dl_load), .DELAY_LINE_MOVE(r9_dl_move),
    .DELAY_LINE_DIRECTION(r9_dl_dir), .DELAY_LINE_OUT_OF_RANGE(r9_oor), .TAP_OUT(r9_tap_out)
  );

  function automatic logic [71:0] pack_shadow();
    logic [71:0] v;
    for (int c = 0; c < 9; c++) v[c*8 +: 8] = 8'(shadow[c]);
    return v;
  endfunction

  // Issue one request (accept edge = cycle 0) and capture outputs for cycles 1..ncyc.
  task automatic run_req(input int ch, input int tgt, input bit load, input int ncyc,
                         input int oor_cyc, input int rst_cyc, input bit hold,
                         input int ch2, input int tgt2, input bit load2);
    int waited = 0;
    while (req_ready !== 1'b1 && waited < 40) begin
      @(posedge clk); #1; waited++;
    end
    if (req_ready !== 1'b1) begin
      tests++; failed++;
      $display("FAIL ready_timeout: REQ_READY=%b, required 1", req_ready);
      return;
    end
    req_ch = 4'(ch); req_tap = 8'(tgt); req_load = load; req_valid = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      req_ch = 4'(ch2); req_tap = 8'(tgt2); req_load = load2;
    end else begin
      req_valid = 1'b0;
    end
    for (int n = 1; n <= ncyc; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      cap_ld[n] = dl_load; cap_mv[n] = dl_move; cap_dr[n] = dl_dir;
      cap_dn[n] = done; cap_de[n] = done_err; cap_rdy[n] = req_ready; cap_tap[n] = tap_out;
      if (n == oor_cyc) dl_oor[ch] = 1'b1;
      if (n == oor_cyc + 1) dl_oor = '0;
      if (n == rst_cyc) rst = 1'b1;
      if (rst_cyc != 0 && n == rst_cyc + 1) rst = 1'b0;
    end
    req_valid = 1'b0;
    dl_oor = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_ch = 4'd0; req_tap = 8'd5; req_load = 1'b0; dl_oor = '0;
    r9_valid = 1'b0; r9_ch = '0; r9_tap = '0; r9_load = 1'b0; r9_oor = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (req_ready !== 1'b0) begin failed++; $display("FAIL rst_ready: got %b, required 0", req_ready); end
    tests++; if ({done, done_err} !== 2'b00) begin failed++; $display("FAIL rst_done: got %b, required 00", {done, done_err}); end
    tests++; if ({dl_load, dl_move, dl_dir} !== 27'd0) begin failed++; $display("FAIL rst_pulses: got %h, required 0", {dl_load, dl_move, dl_dir}); end
    tests++; if (tap_out !== pack_shadow()) begin failed++; $display("FAIL rst_taps: got %h, required %h", tap_out, pack_shadow()); end
    rst = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (req_ready !== 1'b1) begin failed++; $display("FAIL rst_ready_release: got %b, required 1", req_ready); end
    tests++; if (done !== 1'b0) begin failed++; $display("FAIL rst_no_accept: DONE got %b, required 0", done); end
  endtask

  task automatic test_increment();
    logic [8:0] emv, edr;
    run_req(2, 4, 1'b0, 15, 0, 0, 1'b0, 0, 0, 1'b0);
    for (int n = 1; n <= 15; n++) begin
      emv = (n == 2 || n == 6 || n == 10) ? 9'h004 : 9'h000;
      edr = (n <= 13) ? 9'h004 : 9'h000;
      tests++; if (cap_mv[n] !== emv) begin failed++; $display("FAIL inc_move c%0d: got %h, required %h", n, cap_mv[n], emv); end
      tests++; if (cap_dr[n] !== edr) begin failed++; $display("FAIL inc_dir c%0d: got %h, required %h", n, cap_dr[n], edr); end
      tests++; if (cap_ld[n] !== 9'h000) begin failed++; $display("FAIL inc_load c%0d: got %h, required 000", n, cap_ld[n]); end
      tests++; if ({cap_dn[n], cap_de[n]} !== {n == 14, 1'b0}) begin failed++; $display("FAIL inc_done c%0d: got %b, required %b", n, {cap_dn[n], cap_de[n]}, {n == 14, 1'b0}); end
      tests++; if (cap_rdy[n] !== (n == 15)) begin failed++; $display("FAIL inc_ready c%0d: got %b, required %b", n, cap_rdy[n], n == 15); end
    end
    tests++; if (cap_tap[7][2*8 +: 8] !== 8'd3) begin failed++; $display("FAIL inc_tap_mid: got %0d, required 3", cap_tap[7][2*8 +: 8]); end
    shadow[2] = 4;
    tests++; if (cap_tap[15] !== pack_shadow()) begin failed++; $display("FAIL inc_taps: got %h, required %h", cap_tap[15], pack_shadow()); end
  endtask

  task automatic test_load_decrement();
    run_req(2, 0, 1'b1, 11, 0, 0, 1'b0, 0, 0, 1'b0);
    for (int n = 1; n <= 11; n++) begin
      tests++; if (cap_ld[n] !== ((n == 1) ? 9'h004 : 9'h000)) begin failed++; $display("FAIL ld_load c%0d: got %h", n, cap_ld[n]); end
      tests++; if (cap_mv[n] !== ((n == 6) ? 9'h004 : 9'h000)) begin failed++; $display("FAIL ld_move c%0d: got %h", n, cap_mv[n]); end
      tests++; if (cap_dr[n] !== 9'h000) begin failed++; $display("FAIL ld_dir c%0d: got %h, required 000", n, cap_dr[n]); end
      tests++; if ({cap_dn[n], cap_de[n]} !== {n == 10, 1'b0}) begin failed++; $display("FAIL ld_done c%0d: got %b, required %b", n, {cap_dn[n], cap_de[n]}, {n == 10, 1'b0}); end
    end
    tests++; if (cap_tap[1][2*8 +: 8] !== 8'd4) begin failed++; $display("FAIL ld_tap_c1: got %0d, required 4", cap_tap[1][2*8 +: 8]); end
    tests++; if (cap_tap[2][2*8 +: 8] !== 8'd1) begin failed++; $display("FAIL ld_tap_c2: got %0d, required 1", cap_tap[2][2*8 +: 8]); end
    shadow[2] = 0;
    tests++; if (cap_tap[11] !== pack_shadow()) begin failed++; $display("FAIL ld_taps: got %h, required %h", cap_tap[11], pack_shadow()); end
  endtask

  task automatic test_out_of_range();
    run_req(0, 5, 1'b0, 16, 13, 0, 1'b0, 0, 0, 1'b0);
    for (int n = 1; n <= 16; n++) begin
      tests++; if (cap_mv[n] !== ((n == 2 || n == 6 || n == 10) ? 9'h001 : 9'h000)) begin failed++; $display("FAIL oor_move c%0d: got %h", n, cap_mv[n]); end
      tests++; if ({cap_dn[n], cap_de[n]} !== {n == 14, n == 14}) begin failed++; $display("FAIL oor_done c%0d: got %b, required %b", n, {cap_dn[n], cap_de[n]}, {n == 14, n == 14}); end
    end
    tests++; if (cap_tap[13][7:0] !== 8'd4) begin failed++; $display("FAIL oor_tap_pre: got %0d, required 4", cap_tap[13][7:0]); end
    shadow[0] = 3;
    tests++; if (cap_tap[14] !== pack_shadow()) begin failed++; $display("FAIL oor_taps: got %h, required %h", cap_tap[14], pack_shadow()); end
  endtask

  task automatic test_zero_distance();
    run_req(8, 1, 1'b0, 3, 0, 0, 1'b0, 0, 0, 1'b0);
    for (int n = 1; n <= 3; n++) begin
      tests++; if ({cap_ld[n], cap_mv[n], cap_dr[n]} !== 27'd0) begin failed++; $display("FAIL zero_pulses c%0d: got %h, required 0", n, {cap_ld[n], cap_mv[n], cap_dr[n]}); end
      tests++; if ({cap_dn[n], cap_de[n], cap_rdy[n]} !== {n == 2, 1'b0, n == 3}) begin failed++; $display("FAIL zero_done c%0d: got %b, required %b", n, {cap_dn[n], cap_de[n], cap_rdy[n]}, {n == 2, 1'b0, n == 3}); end
    end
  endtask

  task automatic test_reject_channel();
    run_req(9, 0, 1'b1, 3, 0, 0, 1'b0, 0, 0, 1'b0);
    for (int n = 1; n <= 3; n++) begin
      tests++; if ({cap_ld[n], cap_mv[n], cap_dr[n]} !== 27'd0) begin failed++; $display("FAIL rejch_pulses c%0d: got %h, required 0", n, {cap_ld[n], cap_mv[n], cap_dr[n]}); end
      tests++; if ({cap_dn[n], cap_de[n], cap_rdy[n]} !== {n == 1, n == 1, n == 2 || n == 3}) begin failed++; $display("FAIL rejch_done c%0d: got %b", n, {cap_dn[n], cap_de[n], cap_rdy[n]}); end
    end
    tests++; if (cap_tap[3] !== pack_shadow()) begin failed++; $display("FAIL rejch_taps: got %h, required %h", cap_tap[3], pack_shadow()); end
  endtask

  task automatic test_reject_tap();
    logic [80:0] einit;
    for (int c = 0; c < 9; c++) einit[c*9 +: 9] = 9'd1;
    r9_ch = 4'd0; r9_tap = 9'd256; r9_load = 1'b0; r9_valid = 1'b1;
    @(posedge clk); #1;
    r9_valid = 1'b0;
    tests++; if ({r9_done, r9_err} !== 2'b11) begin failed++; $display("FAIL rejtap_done: got %b, required 11", {r9_done, r9_err}); end
    tests++; if ({r9_dl_load, r9_dl_move, r9_dl_dir} !== 27'd0) begin failed++; $display("FAIL rejtap_pulses: got %h, required 0", {r9_dl_load, r9_dl_move, r9_dl_dir}); end
    tests++; if (r9_ready !== 1'b0) begin failed++; $display("FAIL rejtap_busy: got %b, required 0", r9_ready); end
    @(posedge clk); #1;
    tests++; if ({r9_done, r9_ready} !== 2'b01) begin failed++; $display("FAIL rejtap_after: got %b, required 01", {r9_done, r9_ready}); end
    tests++; if (r9_tap_out !== einit) begin failed++; $display("FAIL rejtap_taps: got %h, required %h", r9_tap_out, einit); end
  endtask

  task automatic test_back_to_back();
    run_req(3, 2, 1'b0, 14, 0, 0, 1'b1, 3, 1, 1'b0);
    for (int n = 1; n <= 14; n++) begin
      tests++; if (cap_mv[n] !== ((n == 2 || n == 9) ? 9'h008 : 9'h000)) begin failed++; $display("FAIL b2b_move c%0d: got %h", n, cap_mv[n]); end
      tests++; if (cap_dr[n] !== ((n <= 5) ? 9'h008 : 9'h000)) begin failed++; $display("FAIL b2b_dir c%0d: got %h", n, cap_dr[n]); end
      tests++; if ({cap_dn[n], cap_de[n]} !== {n == 6 || n == 13, 1'b0}) begin failed++; $display("FAIL b2b_done c%0d: got %b", n, {cap_dn[n], cap_de[n]}); end
      tests++; if (cap_rdy[n] !== (n == 7 || n == 14)) begin failed++; $display("FAIL b2b_ready c%0d: got %b, required %b", n, cap_rdy[n], n == 7 || n == 14); end
    end
    tests++; if (cap_tap[9][3*8 +: 8] !== 8'd2) begin failed++; $display("FAIL b2b_tap_mid: got %0d, required 2", cap_tap[9][3*8 +: 8]); end
    shadow[3] = 1;
    tests++; if (cap_tap[14] !== pack_shadow()) begin failed++; $display("FAIL b2b_taps: got %h, required %h", cap_tap[14], pack_shadow()); end
  endtask

  task automatic test_reset_mid_move();
    logic [8:0] edr;
    // Request A: ch1 1->4; reset sampled at the end of cycle 7; held request B
    // (ch1, LOAD, target 2) is accepted at the end of cycle 9.
    run_req(1, 4, 1'b0, 20, 0, 7, 1'b1, 1, 2, 1'b1);
    for (int n = 1; n <= 20; n++) begin
      edr = ((n <= 7) || (n >= 14 && n <= 18)) ? 9'h002 : 9'h000;
      tests++; if (cap_mv[n] !== ((n == 2 || n == 6 || n == 15) ? 9'h002 : 9'h000)) begin failed++; $display("FAIL rmid_move c%0d: got %h", n, cap_mv[n]); end
      tests++; if (cap_ld[n] !== ((n == 10) ? 9'h002 : 9'h000)) begin failed++; $display("FAIL rmid_load c%0d: got %h", n, cap_ld[n]); end
      tests++; if (cap_dr[n] !== edr) begin failed++; $display("FAIL rmid_dir c%0d: got %h, required %h", n, cap_dr[n], edr); end
      tests++; if ({cap_dn[n], cap_de[n]} !== {n == 19, 1'b0}) begin failed++; $display("FAIL rmid_done c%0d: got %b", n, {cap_dn[n], cap_de[n]}); end
      tests++; if (cap_rdy[n] !== (n == 9 || n == 20)) begin failed++; $display("FAIL rmid_ready c%0d: got %b, required %b", n, cap_rdy[n], n == 9 || n == 20); end
    end
    tests++; if (cap_tap[7][1*8 +: 8] !== 8'd3) begin failed++; $display("FAIL rmid_tap_pre: got %0d, required 3", cap_tap[7][1*8 +: 8]); end
    for (int c = 0; c < 9; c++) shadow[c] = 1;
    tests++; if (cap_tap[8] !== pack_shadow()) begin failed++; $display("FAIL rmid_taps_rst: got %h, required %h", cap_tap[8], pack_shadow()); end
    shadow[1] = 2;
    tests++; if (cap_tap[20] !== pack_shadow()) begin failed++; $display("FAIL rmid_taps_end: got %h, required %h", cap_tap[20], pack_shadow()); end
  endtask

  initial begin
    for (int c = 0; c < 9; c++) shadow[c] = 1;
    test_reset();
    test_increment();
    test_load_decrement();
    test_out_of_range();
    test_zero_distance();
    test_reject_channel();
    test_reject_tap();
    test_back_to_back();
    test_reset_mid_move();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ddr_iod_delay_stepper.md
# ddr_iod_delay_stepper

Multi-channel delay-line tap controller for DDR PHY lane IODs. It accepts one tap-move request at a time over a valid/ready handshake. It then drives per-channel DELAY_LINE_LOAD / DELAY_LINE_MOVE / DELAY_LINE_DIRECTION pulses with enforced settle gaps, and keeps a shadow tap count per channel. It sits between the training sequencer and the NUM_CH DQ/DM IOD wrappers of one lane. It also reports delay-line out-of-range aborts.

## Interface
Parameters:
- NUM_CH, 9: channels driven (8 DQ + DM); legal 1..32.
- TAP_W, 8: tap counter width.
- MAX_TAP, 255: highest legal tap; must be < 2**TAP_W.
- INIT_TAP, 1: tap value after reset and after a DELAY_LINE_LOAD pulse.
- MOVE_GAP, 3: idle cycles after every LOAD/MOVE pulse; legal 1..15.

Ports (CH_W = max(1, $clog2(NUM_CH))):
- FAB_CLK  in  1  fabric clock; all logic on rising edge.
- SYNC_RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  controller idle; a request is accepted on an edge where REQ_VALID && REQ_READY.
- REQ_CH  in  CH_W  target channel.
- REQ_TAP  in  TAP_W  target tap.
- REQ_LOAD  in  1  1 = issue LOAD (tap := INIT_TAP) before stepping.
- DONE  out  1  one-cycle completion pulse.
- DONE_ERR  out  1  valid with DONE; 1 = request rejected or aborted.
- DELAY_LINE_LOAD  out  NUM_CH  per-channel load pulse.
- DELAY_LINE_MOVE  out  NUM_CH  per-channel move pulse.
- DELAY_LINE_DIRECTION  out  NUM_CH  per-channel direction; 1 = increment.
- DELAY_LINE_OUT_OF_RANGE  in  NUM_CH  per-channel IOD range flag.
- TAP_OUT  out  NUM_CH*TAP_W  shadow taps; channel c at [c*TAP_W +: TAP_W].

## Operation
- Request fields are latched on accept. Only channel REQ_CH is ever driven. All other bits of LOAD/MOVE/DIRECTION stay 0.
- States:
  - IDLE: REQ_READY=1. On accept, go to DONE with DONE_ERR=1 if REQ_CH >= NUM_CH or REQ_TAP > MAX_TAP; no pulses are issued. Otherwise go to LOAD if REQ_LOAD, else SETUP.
  - LOAD: DELAY_LINE_LOAD[ch]=1 for one cycle; tap[ch] := INIT_TAP; then GAP, then SETUP.
  - SETUP: if tap == target, go to DONE (ok). Otherwise drive DIRECTION[ch] = (target > tap) and go to MOVE. DIRECTION is held through every MOVE/GAP until DONE.
  - MOVE: DELAY_LINE_MOVE[ch]=1 for one cycle; tap[ch] ±1; then GAP.
  - GAP: MOVE_GAP cycles. In the last GAP cycle after a MOVE, if DELAY_LINE_OUT_OF_RANGE[ch]=1: revert tap[ch] by one step and go to DONE with ERR. Otherwise go to MOVE if tap != target, else DONE.
  - DONE: DONE=1 for one cycle, DIRECTION cleared; next state IDLE.
- DELAY_LINE_OUT_OF_RANGE is ignored outside post-MOVE GAP and on unselected channels. A LOAD never aborts.
- Tap arithmetic is modulo 2**TAP_W, but wrap is unreachable because target ≤ MAX_TAP.

## Timing
- Reset (edge with SYNC_RST=1): state IDLE; REQ_READY=0 while SYNC_RST high, 1 on the first cycle after; DONE, DONE_ERR, LOAD, MOVE, DIRECTION = 0; every TAP_OUT = INIT_TAP.
- Reset mid-request aborts at that edge: no further pulses and no DONE. Shadow taps become INIT_TAP, so software must issue a REQ_LOAD per channel afterwards.
- Cycle numbering: accept edge = cycle 0. All outputs are registered.
  - No-load request, distance d ≥ 0: SETUP in cycle 1; MOVE pulses at cycles 2 + k*(1+MOVE_GAP), k=0..d-1; DONE at cycle 2 + d*(1+MOVE_GAP).
  - REQ_LOAD adds 1+MOVE_GAP cycles: LOAD pulse at cycle 1, with d measured from INIT_TAP.
  - Rejected request: DONE/DONE_ERR at cycle 1.
- TAP_OUT updates the cycle after each LOAD/MOVE pulse; an OOR revert takes effect with DONE.
- Back-to-back: REQ_READY is 1 the cycle after DONE, so with REQ_VALID held high the next accept is DONE+1. REQ_READY=0 from cycle 1 until then.

## Test plan
- Reset: hold SYNC_RST 3 cycles with REQ_VALID=1 -> no accept, all outputs 0, each TAP_OUT=1, REQ_READY=1 one cycle after release.
- Increment, MOVE_GAP=3: REQ_CH=2, REQ_TAP=4, REQ_LOAD=0 from tap 1 -> DIRECTION[2]=1 cycles 1..13; MOVE[2] pulses at 2,6,10; DONE=1, ERR=0 at 14; TAP_OUT ch2=4; no other channel toggles.
- Load + decrement: ch2 at 4, REQ_LOAD=1, REQ_TAP=0 -> LOAD[2] at cycle 1; DIRECTION[2]=0; MOVE[2] at 6; DONE at 10; TAP_OUT ch2=0.
- Out of range: ch0 at 1, target 5, force OOR[0]=1 during cycle 13 (last GAP after 3rd move) -> DONE, ERR=1 at 14; TAP_OUT ch0=3; no 4th MOVE.
- Rejects: REQ_CH=9 (NUM_CH=9), then REQ_TAP=256 with TAP_W=9, MAX_TAP=255 -> each gives DONE+ERR at cycle 1, zero pulses, taps unchanged.
- Reset mid-move: assert SYNC_RST at cycle 7 of a 3-step request -> no MOVE at 10, no DONE, TAP_OUT=INIT_TAP; a subsequent held request is accepted first cycle after release.
